dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with round-robin fairness, bounded lock,
// misaligned-access trapping and a registered one-cycle response path.
module dmem_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        rerr,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    localparam logic [8:0] LMAX = 9'(LOCK_MAX);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last;
    logic        last_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [8:0]  cnt_inc;
    logic        hold;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        aligned;

    // Grants are forced low while reset is held so nothing reaches memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        if (gnt0) begin
            sel_we    = we0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (gnt1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    assign aligned = (sel_addr[1:0] == 2'b00);
    assign mem_we  = sel_we & any_gnt & aligned;
    assign mem_a   = {sel_addr[31:2], 2'b00};
    assign mem_wd  = sel_wdata;

    assign cnt_inc = {1'b0, cnt} + 9'd1;
    assign hold    = (state == LOCK0) ? (req0 & lock0) : (req1 & lock1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        if (gnt0) begin
            last_nxt = 1'b0;
        end else if (gnt1) begin
            last_nxt = 1'b1;
        end
        case (state)
            IDLE: begin
                if (gnt0 && lock0) begin
                    state_nxt = LOCK0;
                    cnt_nxt   = 8'd1;
                end else if (gnt1 && lock1) begin
                    state_nxt = LOCK1;
                    cnt_nxt   = 8'd1;
                end
            end
            LOCK0, LOCK1: begin
                // The counter counts granted cycles, including the entry grant.
                if (!hold || cnt_inc >= LMAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt_inc[7:0];
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Writes and misaligned accesses answer with zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= 32'd0;
            rerr    <= 1'b0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (any_gnt) begin
                rdata <= (!sel_we && aligned) ? mem_rd : 32'd0;
                rerr  <= !aligned;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table, reset-abort sequence and random scoreboard run
// for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rerr, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        mem_init;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    int n_checks;
    int n_fail;

    dmem_arbiter #(.LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .rerr(rerr),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
    end

    assign mem_rd = mem[mem_a[9:2]];

    typedef struct {
        logic        r0, r1, w0, w1, l0, l1;
        logic [31:0] a0, a1, d0, d1;
        logic        g0, g1, mwe;
        logic [31:0] ma, mwd;
        logic        v0, v1, err;
        logic [31:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r0, r1, w0, w1, l0, l1,
        input logic [31:0] a0, a1, d0, d1,
        input logic g0, g1, mwe,
        input logic [31:0] ma, mwd,
        input logic v0, v1, err,
        input logic [31:0] rd
    );
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.l0 = l0; v.l1 = l1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.v0 = v0; v.v1 = v1; v.err = err; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, r1, w0, w1, l0, l1,
                         input logic [31:0] a0, a1, d0, d1);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    logic        acc0, acc1, s_we, s_al;
    logic [31:0] s_a, s_d, e_rd;
    logic        e_err;
    int          bad;

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        mem_init = 1'b1;
        drive(1, 1, 1, 1, 0, 0, 32'h10, 32'h14, 32'h1, 32'h2);

        // Table: inputs | gnt0 gnt1 mem_we mem_a mem_wd | rv0 rv1 rerr rdata
        vq.push_back(mk(1,1,0,0,0,0, 32'h20,32'h24,0,0, 1,0,0,32'h20,0, 1,0,0,32'hA000_0008));
        vq.push_back(mk(1,1,0,0,0,0, 32'h20,32'h24,0,0, 0,1,0,32'h24,0, 0,1,0,32'hA000_0009));
        vq.push_back(mk(1,1,0,0,0,0, 32'h20,32'h24,0,0, 1,0,0,32'h20,0, 1,0,0,32'hA000_0008));
        vq.push_back(mk(1,1,0,0,0,0, 32'h20,32'h24,0,0, 0,1,0,32'h24,0, 0,1,0,32'hA000_0009));
        vq.push_back(mk(1,0,1,0,0,0, 32'h10,0,32'hDEADBEEF,0, 1,0,1,32'h10,32'hDEADBEEF, 1,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0, 32'h10,0,0,0, 1,0,0,32'h10,0, 1,0,0,32'hDEADBEEF));
        vq.push_back(mk(0,1,0,1,0,0, 0,32'h13,0,32'h12345678, 0,1,0,32'h10,32'h12345678, 0,1,1,0));
        vq.push_back(mk(0,1,0,0,0,0, 0,32'h10,0,0, 0,1,0,32'h10,0, 0,1,0,32'hDEADBEEF));
        vq.push_back(mk(0,1,0,0,0,0, 0,32'h22,0,0, 0,1,0,32'h20,0, 0,1,1,0));
        vq.push_back(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 0,1,0,32'h4,0, 0,1,0,32'hA000_0001));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,0,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(1,1,0,0,0,0, 0,32'h4,0,0, 0,1,0,32'h4,0, 0,1,0,32'hA000_0001));
        vq.push_back(mk(1,1,0,0,1,0, 0,32'h4,0,0, 1,0,0,0,0, 1,0,0,32'hA000_0000));
        vq.push_back(mk(0,1,0,0,1,0, 0,32'h4,0,0, 0,0,0,0,0, 0,0,0,32'hA000_0000));
        vq.push_back(mk(0,1,0,0,0,0, 0,32'h4,0,0, 0,1,0,32'h4,0, 0,1,0,32'hA000_0001));

        repeat (2) @(posedge clk);
        #1;
        check("rst.gnt0", 32'(gnt0), 0);
        check("rst.gnt1", 32'(gnt1), 0);
        check("rst.mem_we", 32'(mem_we), 0);
        check("rst.rvalid0", 32'(rvalid0), 0);
        check("rst.rvalid1", 32'(rvalid1), 0);
        check("rst.rdata", rdata, 0);
        check("rst.rerr", 32'(rerr), 0);
        @(negedge clk);
        rst      = 1'b0;
        mem_init = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].r0, vq[i].r1, vq[i].w0, vq[i].w1, vq[i].l0, vq[i].l1,
                  vq[i].a0, vq[i].a1, vq[i].d0, vq[i].d1);
            #1;
            check($sformatf("v%0d.gnt0", i), 32'(gnt0), 32'(vq[i].g0));
            check($sformatf("v%0d.gnt1", i), 32'(gnt1), 32'(vq[i].g1));
            check($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vq[i].mwe));
            check($sformatf("v%0d.mem_a", i), mem_a, vq[i].ma);
            check($sformatf("v%0d.mem_wd", i), mem_wd, vq[i].mwd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.rvalid0", i), 32'(rvalid0), 32'(vq[i].v0));
            check($sformatf("v%0d.rvalid1", i), 32'(rvalid1), 32'(vq[i].v1));
            check($sformatf("v%0d.rerr", i), 32'(rerr), 32'(vq[i].err));
            check($sformatf("v%0d.rdata", i), rdata, vq[i].rd);
        end

        // Reset while locked to requester 1 with a transfer in flight.
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 1, 0, 32'h8, 0, 0);
        #1;
        check("lk1.enter_gnt1", 32'(gnt1), 1);
        @(posedge clk);
        #1;
        check("lk1.rvalid1", 32'(rvalid1), 1);
        @(negedge clk);
        #1;
        check("lk1.hold_gnt1", 32'(gnt1), 1);
        #1;
        rst = 1'b1;
        #1;
        check("lk1.rst_rvalid1", 32'(rvalid1), 0);
        check("lk1.rst_gnt1", 32'(gnt1), 0);
        check("lk1.rst_mem_we", 32'(mem_we), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("lk1.post_rvalid1", 32'(rvalid1), 0);
        drive(1, 1, 0, 0, 0, 0, 32'h8, 32'h8, 0, 0);
        #1;
        check("lk1.tie_gnt0", 32'(gnt0), 1);
        check("lk1.tie_gnt1", 32'(gnt1), 0);
        @(posedge clk);
        #1;
        check("lk1.resp_rvalid0", 32'(rvalid0), 1);
        check("lk1.resp_rvalid1", 32'(rvalid1), 0);

        // Random traffic against a reference memory.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  rnd_addr(), rnd_addr(), $urandom, $urandom);
            #1;
            check("rnd.one_grant", 32'(gnt0 & gnt1), 0);
            check("rnd.gnt_needs_req",
                  32'((gnt0 & !req0) | (gnt1 & !req1)), 0);
            acc0 = gnt0 & req0;
            acc1 = gnt1 & req1;
            s_we = acc0 ? we0 : we1;
            s_a  = acc0 ? addr0 : addr1;
            s_d  = acc0 ? wdata0 : wdata1;
            s_al = (s_a[1:0] == 2'b00);
            e_rd  = rdata;
            e_err = rerr;
            if (acc0 | acc1) begin
                check("rnd.mem_a", mem_a, {s_a[31:2], 2'b00});
                check("rnd.mem_we", 32'(mem_we), 32'(s_we & s_al));
                e_err = !s_al;
                e_rd  = (!s_we && s_al) ? ref_mem[s_a[9:2]] : 32'd0;
                if (s_we && s_al) ref_mem[s_a[9:2]] = s_d;
            end else begin
                check("rnd.idle_mem_we", 32'(mem_we), 0);
            end
            @(posedge clk);
            #1;
            check("rnd.rvalid0", 32'(rvalid0), 32'(acc0));
            check("rnd.rvalid1", 32'(rvalid1), 32'(acc1));
            check("rnd.rdata", rdata, e_rd);
            check("rnd.rerr", 32'(rerr), 32'(e_err));
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("rnd.mem_contents", 32'(bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
